seven_seg_scan_decoder: RTL and testbench

SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

---
 rtl/seven_seg_scan_decoder.sv | 157 +++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_decoder
// Description : Recovers 4-bit digit codes from a multiplexed, active-low
//               seven-segment display bus. Hex letters A..F are decoded only
//               when SEVEN_SEG_HEX_DECODE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_n,
    input  logic [7:0]  an_n,
    output logic [31:0] digits,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        err_pattern,
    output logic        err_multi_an
);
    localparam logic [7:0] c_CNT_MAX = 8'(STABLE_CYCLES - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETTLE = 2'd1;
    localparam logic [1:0] c_HOLD   = 2'd2;

    logic [6:0] r_seg_m, r_seg_s;
    logic [7:0] r_an_m, r_an_s;
    logic [7:0] r_cnt;
    logic [1:0] r_state, w_state_next;
    logic [7:0] r_seen;
    logic       w_same, w_any_an, w_one_hot, w_multi, w_capture;
    logic [7:0] w_an_low, w_cap_mask;
    logic       w_known, w_blank;
    logic [3:0] w_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_m <= 7'h7F;
            r_seg_s <= 7'h7F;
            r_an_m  <= 8'hFF;
            r_an_s  <= 8'hFF;
        end else begin
            r_seg_m <= seg_n;
            r_seg_s <= r_seg_m;
            r_an_m  <= an_n;
            r_an_s  <= r_an_m;
        end
    end

    // Counter tracks how long the value now held in the synchronizer output has been constant
    assign w_same    = ({r_an_m, r_seg_m} == {r_an_s, r_seg_s});
    assign w_an_low  = ~r_an_s;
    assign w_any_an  = (w_an_low != 8'h00);
    assign w_one_hot = w_any_an && ((w_an_low & (w_an_low - 8'd1)) == 8'h00);
    assign w_multi   = w_any_an && !w_one_hot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (!w_same) begin
            r_cnt <= 8'd0;
        end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_any_an) w_state_next = c_SETTLE;
            end
            c_SETTLE: begin
                if (!w_any_an)               w_state_next = c_IDLE;
                else if (r_cnt == c_CNT_MAX) w_state_next = c_HOLD;
            end
            c_HOLD: begin
                // A dropped counter means the sample changed since capture
                if (!w_any_an)               w_state_next = c_IDLE;
                else if (r_cnt != c_CNT_MAX) w_state_next = c_SETTLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_capture = (r_state == c_SETTLE) && w_any_an && (r_cnt == c_CNT_MAX);
    end

    always_comb begin
        w_known = 1'b1;
        w_blank = 1'b0;
        w_code  = 4'h0;
        case (r_seg_s)
            7'b1000000: w_code = 4'h0;
            7'b1111001: w_code = 4'h1;
            7'b0100100: w_code = 4'h2;
            7'b0110000: w_code = 4'h3;
            7'b0011001: w_code = 4'h4;
            7'b0010010: w_code = 4'h5;
            7'b0000010: w_code = 4'h6;
            7'b1011000: w_code = 4'h7;
            7'b0000000: w_code = 4'h8;
            7'b0010000: w_code = 4'h9;
`ifdef SEVEN_SEG_HEX_DECODE_EN
            7'b0001000: w_code = 4'hA;
            7'b0000011: w_code = 4'hB;
            7'b1000110: w_code = 4'hC;
            7'b0100001: w_code = 4'hD;
            7'b0000110: w_code = 4'hE;
            7'b0001110: w_code = 4'hF;
`endif
            7'b1111111: begin
                w_known = 1'b0;
                w_blank = 1'b1;
            end
            default:    w_known = 1'b0;
        endcase
    end

    assign w_cap_mask = (w_capture && w_one_hot) ? w_an_low : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits       <= 32'h0;
            digit_valid  <= 8'h00;
            r_seen       <= 8'h00;
            frame_done   <= 1'b0;
            err_pattern  <= 1'b0;
            err_multi_an <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_cap_mask[i]) begin
                    digit_valid[i] <= w_known;
                    if (w_known) digits[4*i +: 4] <= w_code;
                end
            end
            // A full mask clears while still accepting a capture landing in the same cycle
            r_seen       <= ((r_seen == 8'hFF) ? 8'h00 : r_seen) | w_cap_mask;
            frame_done   <= (r_seen == 8'hFF);
            err_pattern  <= w_capture && w_one_hot && !w_known && !w_blank;
            err_multi_an <= w_capture && w_multi;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_decoder
// Description : Self-checking bench for seven_seg_scan_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_decoder;
    localparam int STABLE = 4;
`ifdef SEVEN_SEG_HEX_DECODE_EN
    localparam int N_CODES = 16;
`else
    localparam int N_CODES = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_n;
    logic [7:0]  an_n;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic        frame_done, err_pattern, err_multi_an;

    seven_seg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
        .digits(digits), .digit_valid(digit_valid), .frame_done(frame_done),
        .err_pattern(err_pattern), .err_multi_an(err_multi_an)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_fd, n_ep, n_em;
    logic [6:0] pat_tbl [16];

    // Reference model: synchronized value history reduced to a run length
    logic [14:0] m_s, m_s1, m_last;
    int          m_run;
    logic [31:0] m_digits;
    logic [7:0]  m_valid, m_seen;
    logic        m_fd, m_ep, m_em;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        int         pos;
        bit         exp_valid;
        logic [3:0] exp_code;
        int         exp_ep;
        int         exp_em;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_decode(input logic [6:0] p);
        if (p == 7'h7F) return -2;
        for (int k = 0; k < N_CODES; k++) if (p == pat_tbl[k]) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_s = '1; m_s1 = '1; m_last = '1; m_run = 1;
        m_digits = 0; m_valid = 0; m_seen = 0;
        m_fd = 0; m_ep = 0; m_em = 0;
    endtask

    task automatic model_edge();
        logic [14:0] v;
        int code, idx;
        v = m_s;
        if (v == m_last) m_run++; else m_run = 1;
        m_last = v;
        m_fd = (m_seen == 8'hFF);
        if (m_fd) m_seen = 0;
        m_ep = 0; m_em = 0;
        if (m_run == STABLE && v[14:7] != 8'hFF) begin
            if ($countones(~v[14:7]) > 1) begin
                m_em = 1;
            end else begin
                idx = 0;
                for (int k = 0; k < 8; k++) if (!v[7+k]) idx = k;
                m_seen[idx] = 1'b1;
                code = ref_decode(v[6:0]);
                m_valid[idx] = (code >= 0);
                if (code >= 0) m_digits[4*idx +: 4] = 4'(code);
                if (code == -1) m_ep = 1;
            end
        end
        m_s  = m_s1;
        m_s1 = {an_n, seg_n};
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check("digits", digits, m_digits);
        check("digit_valid", 32'(digit_valid), 32'(m_valid));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("err_pattern", 32'(err_pattern), 32'(m_ep));
        check("err_multi_an", 32'(err_multi_an), 32'(m_em));
        n_fd += int'(frame_done);
        n_ep += int'(err_pattern);
        n_em += int'(err_multi_an);
    endtask

    task automatic hold(input logic [7:0] an, input logic [6:0] seg, input int n);
        an_n = an; seg_n = seg;
        repeat (n) tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digits"}, digits, 32'h0);
        check({tag, "_valid"}, 32'(digit_valid), 32'h0);
        check({tag, "_pulses"}, 32'({frame_done, err_pattern, err_multi_an}), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_zero("rst");
        tick();
        tick();
        rst = 1'b0;
        n_fd = 0; n_ep = 0; n_em = 0;
    endtask

    initial begin
        logic [31:0] snap_d;
        logic [7:0]  snap_v;
        logic [7:0]  an_r;
        logic [6:0]  seg_r;
        int i0, j0;

        pat_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000,
                    7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110,
                    7'b0001110};
        vecs[0] = '{8'hFE, 7'b0100100, 0, 1'b1, 4'h2, 0, 0};
`ifdef SEVEN_SEG_HEX_DECODE_EN
        vecs[1] = '{8'hFD, 7'b0001000, 1, 1'b1, 4'hA, 0, 0};
        vecs[9] = '{8'hDF, 7'b0000110, 5, 1'b1, 4'hE, 0, 0};
`else
        vecs[1] = '{8'hFD, 7'b0001000, 1, 1'b0, 4'h0, 1, 0};
        vecs[9] = '{8'hDF, 7'b0000110, 5, 1'b0, 4'h0, 1, 0};
`endif
        vecs[2] = '{8'hFB, 7'b1111111, 2, 1'b0, 4'h0, 0, 0};
        vecs[3] = '{8'hF7, 7'b0000000, 3, 1'b1, 4'h8, 0, 0};
        vecs[4] = '{8'hEF, 7'b1010101, 4, 1'b0, 4'h0, 1, 0};
        vecs[5] = '{8'hFC, 7'b0000000, -1, 1'b0, 4'h0, 0, 1};
        vecs[6] = '{8'h7F, 7'b1011000, 7, 1'b1, 4'h7, 0, 0};
        vecs[7] = '{8'hBF, 7'b0010000, 6, 1'b1, 4'h9, 0, 0};
        vecs[8] = '{8'hFE, 7'b1000000, 0, 1'b1, 4'h0, 0, 0};

        an_n = 8'hFF; seg_n = 7'h7F;
        do_reset();

        // Table-driven single captures
        for (int v = 0; v < 10; v++) begin
            hold(8'hFF, 7'h7F, 3);
            snap_d = digits; snap_v = digit_valid;
            n_ep = 0; n_em = 0;
            hold(vecs[v].an, vecs[v].seg, 8);
            check("vec_err_pattern", 32'(n_ep), 32'(vecs[v].exp_ep));
            check("vec_err_multi", 32'(n_em), 32'(vecs[v].exp_em));
            if (vecs[v].pos < 0) begin
                check("vec_multi_digits", digits, snap_d);
                check("vec_multi_valid", 32'(digit_valid), 32'(snap_v));
            end else begin
                check("vec_valid", 32'(digit_valid[vecs[v].pos]), 32'(vecs[v].exp_valid));
                if (vecs[v].exp_valid)
                    check("vec_code", 32'(digits[4*vecs[v].pos +: 4]), 32'(vecs[v].exp_code));
                else
                    check("vec_code_kept", 32'(digits[4*vecs[v].pos +: 4]), 32'(snap_d[4*vecs[v].pos +: 4]));
            end
        end

        // Exact capture latency
        do_reset();
        hold(8'hFF, 7'h7F, 3);
        an_n = 8'hFE; seg_n = 7'b0100100;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("latency_valid", 32'(digit_valid[0]), (c == 6) ? 32'd1 : 32'd0);
        end
        check("latency_code", 32'(digits[3:0]), 32'd2);
        hold(8'hFE, 7'b0100100, 4);
        check("latency_no_err", 32'(n_ep + n_em), 32'd0);

        // Full scan, one frame_done, mask cleared afterwards
        do_reset();
        for (int d = 0; d < 8; d++) hold(~(8'h01 << d), pat_tbl[d+1], 8);
        hold(8'hFF, 7'h7F, 4);
        check("scan_digits", digits, 32'h87654321);
        check("scan_valid", 32'(digit_valid), 32'hFF);
        check("scan_frame_count", 32'(n_fd), 32'd1);
        hold(8'hFE, pat_tbl[5], 8);
        hold(8'hFF, 7'h7F, 4);
        check("scan_mask_cleared", 32'(n_fd), 32'd1);

        // Short glitch inside a stable digit
        do_reset();
        hold(8'hFB, pat_tbl[5], 8);
        hold(8'hFB, 7'b1010101, 2);
        hold(8'hFB, pat_tbl[5], 10);
        check("glitch_digit", 32'(digits[11:8]), 32'd5);
        check("glitch_valid", 32'(digit_valid[2]), 32'd1);
        check("glitch_no_err", 32'(n_ep + n_em), 32'd0);

        // Reset in the middle of SETTLE
        do_reset();
        hold(8'hFF, 7'h7F, 3);
        hold(8'hFE, pat_tbl[3], 4);
        rst = 1'b1;
        model_reset();
        #1;
        check_zero("midrst");
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("midrst_valid", 32'(digit_valid[0]), (c == 6) ? 32'd1 : 32'd0);
        end

        // Randomized traffic against the model
        do_reset();
        for (int s = 0; s < 200; s++) begin
            case ($urandom_range(0, 9))
                0: an_r = 8'hFF;
                1: begin
                    i0 = int'($urandom_range(0, 7));
                    j0 = (i0 + 1 + int'($urandom_range(0, 6))) % 8;
                    an_r = ~((8'h01 << i0) | (8'h01 << j0));
                end
                default: an_r = ~(8'h01 << $urandom_range(0, 7));
            endcase
            case ($urandom_range(0, 3))
                0: seg_r = pat_tbl[$urandom_range(0, 9)];
                1: seg_r = 7'h7F;
                2: seg_r = pat_tbl[$urandom_range(10, 15)];
                default: seg_r = 7'($urandom());
            endcase
            hold(an_r, seg_r, int'($urandom_range(1, 10)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
